pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised pipeline hazard and redirect controller for the TinyRISC-V core. It merges the jump/flush logic in `ctrl_unit` with load-use detection, per-stage external stall requests and synchronous-ROM refetch hold. It drives per-stage hold and bubble-insert controls for an N-stage pipeline and the PC redirect. It also keeps saturating stall and flush performance counters.

## Interface
- `NUM_STAGES`, default 5: number of pipeline stages. Stage 0 = IF/PC, stage 1 = ID. Buffer k sits in front of stage k.
- `EX_STAGE`, default 2: index of the stage that resolves jumps. Range 1..`NUM_STAGES`-1. Load-use hazards are raised at stage `EX_STAGE`-1.
- `ADDR_WIDTH`, default 32: PC width.
- `REG_ADDR_WIDTH`, default 5: register index width.
- `ROM_LAT`, default 0: extra instruction-ROM read cycles after a redirect (0..15).
- `CNT_WIDTH`, default 16: width of the performance counters.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-high reset (reset asserted when 1).
- `jump_en_i` in 1: EX requests a redirect.
- `jump_addr_i` in `ADDR_WIDTH`: redirect target.
- `ex_is_load_i` in 1: the instruction in EX is a load.
- `ex_rd_addr_i` in `REG_ADDR_WIDTH`: EX destination register.
- `id_rs1_addr_i`, `id_rs2_addr_i` in `REG_ADDR_WIDTH`: source registers of the consumer in stage `EX_STAGE`-1.
- `id_rs1_used_i`, `id_rs2_used_i` in 1: the corresponding source register is actually read.
- `ext_stall_req_i` in `NUM_STAGES`: bit k means stage k cannot complete this cycle.
- `stall_o` out `NUM_STAGES`: bit k means stage k holds (bit 0 = PC hold).
- `flush_o` out `NUM_STAGES`: bit k means buffer k loads a bubble at the next edge. Bit 0 is always 0.
- `pc_jump_en_o` out 1: PC loads `pc_jump_addr_o`.
- `pc_jump_addr_o` out `ADDR_WIDTH`: redirect target.
- `stall_cnt_o` out `CNT_WIDTH`: number of cycles with `stall_o[0]`=1.
- `flush_cnt_o` out `CNT_WIDTH`: number of accepted jumps.

## Operation
- **Load-use hazard (`lu`).** `lu` = `ex_is_load_i` & (`ex_rd_addr_i` != 0) & ((`id_rs1_used_i` & rs1 == rd) | (`id_rs2_used_i` & rs2 == rd)). It is treated as a stall request at stage `EX_STAGE`-1.
- **Stall resolution.**
  - `req` = `ext_stall_req_i` with `lu` OR-ed into bit `EX_STAGE`-1.
  - K = highest set bit of `req`.
  - `stall_o[j]` = 1 for all j <= K.
  - `flush_o[K+1]` = 1 if K < `NUM_STAGES`-1.
  - Lower request bits add nothing.
- **Jump acceptance.** A jump is accepted when `jump_en_i`=1 and no `req` bit >= `EX_STAGE` is set. A jump under a downstream stall is ignored; EX re-presents it next cycle.
- **Accepted jump, same cycle:**
  - `pc_jump_en_o`=1 and `pc_jump_addr_o`=`jump_addr_i`.
  - `stall_o[0..EX_STAGE-1]` forced to 0 (this overrides `lu` and upstream requests).
  - `flush_o[1..EX_STAGE]`=1.
  - `flush_cnt_o` increments.
- **FSM states.**
  - RUN: normal operation.
  - REFILL: a counter `rcnt` is active.
- **FSM transitions.**
  - RUN -> REFILL when a jump is accepted and `ROM_LAT` > 0; `rcnt` loads `ROM_LAT`.
  - In REFILL, `flush_o[1]`=1 and `rcnt` decrements only on cycles with `stall_o[1]`=0. On stalled cycles `flush_o[1]`=0 and `rcnt` holds.
  - REFILL -> RUN when `rcnt` reaches 0 through a decrement from 1.
  - An accepted jump while in REFILL reloads `rcnt` to `ROM_LAT` and stays in REFILL.
- **Idle outputs.** When no jump is accepted, `pc_jump_en_o`=0 and `pc_jump_addr_o`=0.
- **Counters.** Both counters saturate at all-ones and never wrap.
- **Elaboration checks.** Parameters out of range (`EX_STAGE`=0 or >= `NUM_STAGES`, `NUM_STAGES` < 3) must fail elaboration.

## Timing
- `stall_o`, `flush_o`, `pc_jump_en_o` and `pc_jump_addr_o` are combinational from the inputs and the current state. Redirect latency is 0 cycles from `jump_en_i`.
- The state, `rcnt` and both counters are registered.
- Reset, synchronous with `rst_n`=1 at the edge:
  - state = RUN, `rcnt` = 0, counters = 0.
  - With all inputs 0, every output is 0.
  - Reset during REFILL aborts the refill; there is no flush on the next cycle.
- The refill bubble count equals `ROM_LAT` unstalled cycles after the jump cycle.
- Simultaneous `lu` and accepted jump: the jump wins and the cycle counts as no stall for `stall_cnt_o`.
- Simultaneous stall at stage >= `EX_STAGE` and `jump_en_i`: stall wins and the counters do not count a jump.

## Test plan
Defaults throughout (`NUM_STAGES`=5, `EX_STAGE`=2) unless stated.
- **Reset.** Hold `rst_n`=1 for 2 cycles with random inputs, then release with inputs 0 -> all outputs 0, counters 0.
- **Load-use.** `ex_is_load_i`=1, rd=5, rs1=5, `id_rs1_used_i`=1 for 1 cycle -> `stall_o`=5'b00011, `flush_o`=5'b00100, `stall_cnt_o`=1. With rd=0 -> no stall.
- **External stall.** `ext_stall_req_i`=5'b01000 -> `stall_o`=5'b01111, `flush_o`=5'b10000. `ext_stall_req_i`=5'b10000 -> `stall_o`=5'b11111, `flush_o`=0.
- **Jump, `ROM_LAT`=0.** `jump_en_i`=1, `jump_addr_i`=0x0000_0100 -> same cycle `pc_jump_en_o`=1, addr 0x100, `flush_o`=5'b00110, `flush_cnt_o`=1 next cycle. Repeat with `lu`=1 -> `stall_o`=0.
- **Jump, `ROM_LAT`=2, stall during refill.** Jump, then `ext_stall_req_i[1]` in cycle +1 -> `flush_o[1]` high in cycles +2 and +3 only, then RUN. A second jump at +2 reloads and gives 2 more bubbles.
- **Blocked jump and saturation.** `jump_en_i` with `ext_stall_req_i[3]`=1 -> `pc_jump_en_o`=0, no count. Set `CNT_WIDTH`=2 and stall 5 cycles -> `stall_cnt_o`=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and redirect controller: load-use detection, per-stage stall
// resolution, jump redirect with ROM refill bubbles, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned NUM_STAGES     = 5,
    parameter int unsigned EX_STAGE       = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ROM_LAT        = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      jump_en_i,
    input  logic [ADDR_WIDTH-1:0]     jump_addr_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [NUM_STAGES-1:0]     ext_stall_req_i,
    output logic [NUM_STAGES-1:0]     stall_o,
    output logic [NUM_STAGES-1:0]     flush_o,
    output logic                      pc_jump_en_o,
    output logic [ADDR_WIDTH-1:0]     pc_jump_addr_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);
    localparam int unsigned RCNT_WIDTH = 4;

    generate
        if (NUM_STAGES < 3) begin : g_bad_num_stages
            $fatal(1, "pipe_hazard_ctrl: NUM_STAGES must be >= 3");
        end
        if (EX_STAGE == 0 || EX_STAGE >= NUM_STAGES) begin : g_bad_ex_stage
            $fatal(1, "pipe_hazard_ctrl: EX_STAGE must be in 1..NUM_STAGES-1");
        end
        if (ROM_LAT > 15) begin : g_bad_rom_lat
            $fatal(1, "pipe_hazard_ctrl: ROM_LAT must be in 0..15");
        end
    endgenerate

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [RCNT_WIDTH-1:0]   rcnt_q, rcnt_d;
    logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]    flush_cnt_q, flush_cnt_d;

    logic                    lu;
    logic                    jump_ok;
    logic [NUM_STAGES-1:0]   req;
    logic [NUM_STAGES-1:0]   stall;
    logic [NUM_STAGES-1:0]   flush;

    // Hazard resolution, redirect outputs and next-state logic.
    always_comb begin
        lu = ex_is_load_i && (ex_rd_addr_i != '0) &&
             ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
              (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
        req = ext_stall_req_i;
        req[EX_STAGE-1] = req[EX_STAGE-1] | lu;

        jump_ok = jump_en_i;
        for (int unsigned k = EX_STAGE; k < NUM_STAGES; k++) begin
            if (req[k]) jump_ok = 1'b0;
        end

        // Highest requesting stage holds itself and everything upstream.
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            stall[k] = |(req >> k);
        end
        flush = '0;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            flush[k] = stall[k-1] & ~stall[k];
        end

        pc_jump_en_o   = 1'b0;
        pc_jump_addr_o = '0;
        if (jump_ok) begin
            pc_jump_en_o   = 1'b1;
            pc_jump_addr_o = jump_addr_i;
            for (int unsigned k = 0; k < EX_STAGE; k++) stall[k] = 1'b0;
            for (int unsigned k = 1; k <= EX_STAGE; k++) flush[k] = 1'b1;
        end

        if (state_q == ST_REFILL && !stall[1]) flush[1] = 1'b1;

        stall_o = stall;
        flush_o = flush;

        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_RUN: begin
                if (jump_ok && ROM_LAT != 0) begin
                    state_d = ST_REFILL;
                    rcnt_d  = RCNT_WIDTH'(ROM_LAT);
                end
            end
            ST_REFILL: begin
                if (jump_ok) begin
                    rcnt_d = RCNT_WIDTH'(ROM_LAT);
                end else if (!stall[1]) begin
                    rcnt_d = rcnt_q - RCNT_WIDTH'(1);
                    if (rcnt_q == RCNT_WIDTH'(1)) state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall[0] && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        flush_cnt_d = flush_cnt_q;
        if (jump_ok && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_RUN;
            rcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
